// File: rtl/alarm_rom_pkg.sv
// Shared constants and grant encoding for the program-ROM arbiter slice.
package alarm_rom_pkg;

  localparam int unsigned ROM_ADDR_W = 15;
  localparam int unsigned ROM_DATA_W = 32;
  localparam int unsigned ROM_DEPTH  = 25600;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_t;

endpackage

// File: rtl/alarm_rom_arbiter_if.sv
// Avalon-MM style master port bundle; the arbiter uses the slave modport.
interface alarm_rom_arbiter_if
  import alarm_rom_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                debugaccess;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/alarm_rom_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant moves only when a grant is issued.
module rr_arb2
  import alarm_rom_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output grant_t     gnt
);

  grant_t last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GNT_M1;
    end else if (gnt_valid) begin
      last_grant <= gnt;
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = GNT_M0;
    if (en && (req != 2'b00)) begin
      gnt_valid = 1'b1;
      if (req == 2'b11) begin
        gnt = (last_grant == GNT_M1) ? GNT_M0 : GNT_M1;
      end else begin
        gnt = req[1] ? GNT_M1 : GNT_M0;
      end
    end
  end

endmodule

// File: rtl/alarm_rom_arbiter.sv
// Shares the single-port program ROM between CPU (m0) and debug/DMA (m1),
// steering one-cycle read returns back to the issuing master.
module alarm_rom_arbiter
  import alarm_rom_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W,
  parameter int unsigned DEPTH  = ROM_DEPTH
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  alarm_rom_arbiter_if.slave  m0,
  alarm_rom_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_debugaccess,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_write,
  output logic                err_range
);

  logic   gnt_valid;
  grant_t gnt;

  logic [ADDR_W-1:0]   sel_address;
  logic                sel_read;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_writedata;
  logic [DATA_W/8-1:0] sel_byteenable;
  logic                sel_debugaccess;

  logic acc_read;
  logic acc_write;
  logic in_range;
  logic forward;

  // Pending read: valid + owner, plus a flag forcing zero data for out-of-range reads.
  logic   pend_valid;
  grant_t pend_owner;
  logic   pend_zero;
  logic [DATA_W-1:0] ret_data;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (!reset && !hold),
    .req       ({m1.read | m1.write, m0.read | m0.write}),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  always_comb begin
    if (gnt == GNT_M1) begin
      sel_address     = m1.address;
      sel_read        = m1.read;
      sel_write       = m1.write;
      sel_writedata   = m1.writedata;
      sel_byteenable  = m1.byteenable;
      sel_debugaccess = m1.debugaccess;
    end else begin
      sel_address     = m0.address;
      sel_read        = m0.read;
      sel_write       = m0.write;
      sel_writedata   = m0.writedata;
      sel_byteenable  = m0.byteenable;
      sel_debugaccess = m0.debugaccess;
    end
  end

  assign acc_read  = gnt_valid && sel_read;
  assign acc_write = gnt_valid && sel_write;
  assign in_range  = 32'(sel_address) < DEPTH;
  assign forward   = in_range && (acc_read || (acc_write && sel_debugaccess));

  always_comb begin
    mem_address     = '0;
    mem_byteenable  = '0;
    mem_writedata   = '0;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    mem_debugaccess = 1'b0;
    if (forward) begin
      mem_address     = sel_address;
      mem_byteenable  = sel_byteenable;
      mem_chipselect  = 1'b1;
      mem_write       = acc_write;
      mem_debugaccess = acc_write;
      mem_writedata   = acc_write ? sel_writedata : '0;
    end
  end

  assign mem_clken = !reset;

  always_comb begin
    ret_data         = pend_zero ? '0 : mem_readdata;
    m0.waitrequest   = !(gnt_valid && (gnt == GNT_M0));
    m1.waitrequest   = !(gnt_valid && (gnt == GNT_M1));
    m0.readdatavalid = 1'b0;
    m1.readdatavalid = 1'b0;
    m0.readdata      = '0;
    m1.readdata      = '0;
    if (pend_valid && !reset) begin
      if (pend_owner == GNT_M1) begin
        m1.readdatavalid = 1'b1;
        m1.readdata      = ret_data;
      end else begin
        m0.readdatavalid = 1'b1;
        m0.readdata      = ret_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_owner <= GNT_M0;
      pend_zero  <= 1'b0;
      err_write  <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      pend_valid <= acc_read;
      if (acc_read) begin
        pend_owner <= gnt;
        pend_zero  <= !in_range;
      end
      if (acc_write && !sel_debugaccess) begin
        err_write <= 1'b1;
      end
      if (gnt_valid && !in_range) begin
        err_range <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_rom_arbiter.sv
// Randomised plus directed bench for alarm_rom_arbiter against a transaction-level model.
module tb_alarm_rom_arbiter;
  import alarm_rom_pkg::*;

  localparam int unsigned AW    = ROM_ADDR_W;
  localparam int unsigned DW    = ROM_DATA_W;
  localparam int unsigned DEPTH = ROM_DEPTH;

  logic clk = 1'b0;
  logic reset;
  logic hold;
  always #5 clk = ~clk;

  alarm_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  alarm_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

  logic [AW-1:0]   mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic [DW-1:0]   mem_writedata;
  logic            mem_chipselect;
  logic            mem_write;
  logic            mem_debugaccess;
  logic            mem_clken;
  logic [DW-1:0]   mem_readdata;
  logic            err_write;
  logic            err_range;

  alarm_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .hold            (hold),
    .m0              (m0_bus),
    .m1              (m1_bus),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_debugaccess (mem_debugaccess),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata),
    .err_write       (err_write),
    .err_range       (err_range)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural ROM driven by the DUT's memory port.
  logic [31:0] rom     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect && (32'(mem_address) < DEPTH)) begin
      if (mem_write) rom[mem_address] <= merge(rom[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata     <= rom[mem_address];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state: who won last, expected pending return, sticky errors.
  int          exp_last;
  bit          pv;
  int          powner;
  logic [31:0] pdata;
  bit          ew, er;
  int          g;
  logic [AW-1:0] sa;
  logic          srd, swr, sdbg;
  logic [31:0]   swd;
  logic [3:0]    sbe;
  bit            s_in;

  task automatic check_outputs();
    bit r0, r1, fwd, v0, v1;
    r0 = m0_bus.read | m0_bus.write;
    r1 = m1_bus.read | m1_bus.write;
    g = -1;
    if (!reset && !hold) begin
      if (r0 && r1) g = (exp_last == 0) ? 1 : 0;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
    end
    if (g == 1) begin
      sa = m1_bus.address; srd = m1_bus.read; swr = m1_bus.write;
      swd = m1_bus.writedata; sbe = m1_bus.byteenable; sdbg = m1_bus.debugaccess;
    end else begin
      sa = m0_bus.address; srd = m0_bus.read; swr = m0_bus.write;
      swd = m0_bus.writedata; sbe = m0_bus.byteenable; sdbg = m0_bus.debugaccess;
    end
    s_in = 32'(sa) < DEPTH;
    fwd  = (g >= 0) && s_in && (srd || (swr && sdbg));

    if (r0 || reset || hold) check("m0_waitrequest", m0_bus.waitrequest, g != 0);
    if (r1 || reset || hold) check("m1_waitrequest", m1_bus.waitrequest, g != 1);
    check("mem_chipselect",  mem_chipselect,  fwd);
    check("mem_write",       mem_write,       fwd && swr);
    check("mem_debugaccess", mem_debugaccess, fwd && swr);
    check("mem_address",     mem_address,     fwd ? sa : '0);
    check("mem_byteenable",  mem_byteenable,  fwd ? sbe : '0);
    check("mem_writedata",   mem_writedata,   (fwd && swr) ? swd : '0);
    check("mem_clken",       mem_clken,       !reset);

    v0 = pv && (powner == 0) && !reset;
    v1 = pv && (powner == 1) && !reset;
    check("m0_readdatavalid", m0_bus.readdatavalid, v0);
    check("m1_readdatavalid", m1_bus.readdatavalid, v1);
    check("m0_readdata",      m0_bus.readdata, v0 ? pdata : 32'h0);
    check("m1_readdata",      m1_bus.readdata, v1 ? pdata : 32'h0);
    check("err_write",        err_write, ew);
    check("err_range",        err_range, er);
  endtask

  task automatic update_model();
    if (reset) begin
      exp_last = 1; pv = 0; ew = 0; er = 0;
    end else begin
      pv = 0;
      if (g >= 0) begin
        exp_last = g;
        if (srd) begin
          pv = 1; powner = g;
          pdata = s_in ? ref_mem[sa] : 32'h0;
        end
        if (swr) begin
          if (!sdbg)     ew = 1;
          else if (s_in) ref_mem[sa] = merge(ref_mem[sa], swd, sbe);
        end
        if (!s_in) er = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] be, input bit dbg);
    if (m == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.writedata = d; m0_bus.byteenable = be; m0_bus.debugaccess = dbg;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.writedata = d; m1_bus.byteenable = be; m1_bus.debugaccess = dbg;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, '0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, '0, 0);
  endtask

  bit            rq_pend [2];
  bit            rq_rd   [2];
  logic [AW-1:0] rq_a    [2];
  logic [31:0]   rq_d    [2];
  logic [3:0]    rq_be   [2];
  bit            rq_dbg  [2];

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      rom[i]     = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      ref_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    end
    mem_readdata = '0;
    exp_last = 1; pv = 0; powner = 0; pdata = '0; ew = 0; er = 0; g = -1;
    hold = 1'b0;
    reset = 1'b1;
    idle_all();
    #1;
    step(); step();

    // Reset release; m0 reads 0x0010, then m1 reads so the next tie goes to m0.
    reset = 1'b0;
    step();
    drive(0, 1, 0, 15'h0010, '0, 4'hF, 0); step();
    drive(0, 0, 0, '0, '0, '0, 0);
    drive(1, 1, 0, 15'h0020, '0, 4'hF, 0); step();
    idle_all(); step();

    // Both masters read continuously: grants alternate m0, m1, m0, m1.
    drive(0, 1, 0, 15'h0030, '0, 4'hF, 0);
    drive(1, 1, 0, 15'h0040, '0, 4'hF, 0);
    for (int i = 0; i < 4; i++) step();
    idle_all(); step();

    // Permitted write then read-back; refused write; out-of-range read.
    drive(1, 0, 1, 15'h0100, 32'hDEADBEEF, 4'hF, 1); step();
    drive(1, 1, 0, 15'h0100, '0, 4'hF, 0); step();
    drive(1, 0, 1, 15'h0104, 32'h12345678, 4'hF, 0); step();
    idle_all(); step();
    drive(0, 1, 0, 15'(DEPTH), '0, 4'hF, 0); step();
    idle_all(); step(); step();

    // Hold blocks both requesters; then reset lands on the cycle of a read.
    hold = 1'b1;
    drive(0, 1, 0, 15'h0050, '0, 4'hF, 0);
    drive(1, 1, 0, 15'h0060, '0, 4'hF, 0);
    step(); step();
    hold = 1'b0;
    step();
    idle_all();
    drive(0, 1, 0, 15'h0070, '0, 4'hF, 0);
    reset = 1'b1; step();
    idle_all(); step();
    reset = 1'b0; step(); step();

    // Randomised traffic with occasional hold and reset.
    for (int m = 0; m < 2; m++) rq_pend[m] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rq_pend[m] && ($urandom_range(0, 99) < 60)) begin
          rq_pend[m] = 1;
          rq_rd[m]   = $urandom_range(0, 3) != 0;
          rq_a[m]    = ($urandom_range(0, 99) < 5) ? 15'($urandom_range(DEPTH, 32767))
                                                   : 15'($urandom_range(0, 63));
          rq_d[m]    = $urandom;
          rq_be[m]   = 4'($urandom_range(1, 15));
          rq_dbg[m]  = $urandom_range(0, 99) < 85;
        end
        if (rq_pend[m]) drive(m, rq_rd[m], !rq_rd[m], rq_a[m], rq_d[m], rq_be[m], rq_dbg[m]);
        else            drive(m, 0, 0, '0, '0, '0, 0);
      end
      hold  = $urandom_range(0, 99) < 10;
      reset = $urandom_range(0, 99) < 2;
      step();
      if (g >= 0) rq_pend[g] = 0;
    end

    hold = 1'b0;
    reset = 1'b1;
    idle_all();
    step();
    reset = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_rom_arbiter.md
# alarm_rom_arbiter

Two-requester arbiter sharing the single-port on-chip program ROM (25600 × 32-bit words, 15-bit word address) between the CPU instruction master (m0) and the debug/DMA master (m1). It sits between the two Avalon-MM masters and the ROM's slave port. It serialises their accesses with round-robin fairness and routes the one-cycle-latency read data back to the master that issued the read. It also gates writes on `debugaccess` and flags illegal accesses.

## Interface
- `ADDR_W`, 15, word-address width.
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`.
- `DEPTH`, 25600, number of implemented words; addresses ≥ `DEPTH` are out of range.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `hold` in 1: 1 = issue no new grants.
- `m0_/m1_address` in `ADDR_W`: word address.
- `m0_/m1_read`, `m0_/m1_write` in 1: request strobes, mutually exclusive per master.
- `m0_/m1_writedata` in `DATA_W`: write data.
- `m0_/m1_byteenable` in 4: byte lanes.
- `m0_/m1_debugaccess` in 1: write permission.
- `m0_/m1_waitrequest` out 1: 1 = request not accepted this cycle.
- `m0_/m1_readdata` out `DATA_W`: read data.
- `m0_/m1_readdatavalid` out 1: readdata valid.
- `mem_address` out `ADDR_W`; `mem_byteenable` out 4; `mem_writedata` out `DATA_W`.
- `mem_chipselect`, `mem_write`, `mem_debugaccess` out 1: ROM command.
- `mem_clken` out 1: ROM clock enable.
- `mem_readdata` in `DATA_W`: ROM output, valid the cycle after the address is issued.
- `err_write`, `err_range` out 1: sticky error flags, cleared only by reset.

## Operation
- Request = `read | write` on a master.
- Grant decision is combinational in the cycle requests are present. Arbitration:
  - One requester: it wins.
  - Both requesting: the master not granted last wins.
  - `last_grant` register updates only on an actual grant; reset value = m1, so m0 wins the first tie.
- Granted master: `waitrequest` = 0 in that cycle and the command is accepted.
- Every other requester: `waitrequest` = 1 and must hold its request stable.
- `hold` = 1 or `reset` = 1: both `waitrequest` = 1 and no command is issued.
- Accepted in-range read:
  - `mem_chipselect` = 1, `mem_write` = 0, address and byteenable forwarded.
  - Pending-read owner tag recorded.
- Accepted write with `debugaccess` = 1 and address in range:
  - `mem_chipselect` = 1, `mem_write` = 1, `mem_debugaccess` = 1, data and byteenable forwarded.
  - No readdatavalid is generated.
- Accepted write with `debugaccess` = 0: acknowledged (`waitrequest` = 0), not forwarded (`mem_chipselect` = 0), `err_write` set.
- Accepted access with address ≥ `DEPTH`: not forwarded, `err_range` set.
  - A read still returns `readdatavalid` = 1 next cycle with `readdata` = 0.
- Read return: in the cycle after issue, the owner's `readdatavalid` = 1 and `readdata` = `mem_readdata` (or 0 for out-of-range). The other master's `readdata` = 0.
- `mem_clken` = 1 always except while `reset` = 1, so a read in flight at `hold` assertion still completes.
- Idle memory outputs: all zero.

## Timing
- Grant-to-memory latency: 0 cycles; command outputs are combinational from the grant.
- Read latency: issue in cycle T, `readdatavalid` in T+1.
- Throughput: one access per cycle; back-to-back reads are fully pipelined, including alternating owners.
- Pending-owner state is one valid bit plus one owner bit.
- Reset mid-read: a read issued in the cycle `reset` is sampled is dropped; no `readdatavalid` follows.
- Reset values:
  - `readdatavalid` 0, `readdata` 0.
  - `err_*` 0.
  - `last_grant` = m1.
  - All `mem_*` 0.
  - `waitrequest` 1 while `reset` = 1.
- Simultaneous requests in consecutive cycles: alternates m0, m1, m0, and so on.

## Structure
- Package `alarm_rom_pkg`:
  - Constants `ROM_ADDR_W` = 15, `ROM_DATA_W` = 32, `ROM_DEPTH` = 25600.
  - Enum `grant_t` {GNT_M0, GNT_M1}.
- Sub-module `rr_arb2`: two-input round-robin grant with `last_grant` register. It is the only stateful arbitration logic; the top level holds the pending-read tag and error flags.

## Test plan
- Reset release, m0 reads 0x0010: `mem_address` = 0x0010 and `mem_chipselect` = 1 in T; `m0_readdatavalid` = 1 with ROM word in T+1; `m1_readdatavalid` = 0.
- m0 and m1 both read continuously for 4 cycles: grants m0, m1, m0, m1; each `readdatavalid` lands one cycle after its own grant; the waiting master sees `waitrequest` = 1.
- m1 writes 0xDEADBEEF to 0x0100 with byteenable 0xF and `debugaccess` = 1, then reads 0x0100: `mem_write` = 1; read returns 0xDEADBEEF.
- m1 writes with `debugaccess` = 0: `waitrequest` = 0, `mem_chipselect` = 0, `err_write` = 1 and stays 1 until reset.
- m0 reads address 25600: `mem_chipselect` = 0; next cycle `readdatavalid` = 1 with `readdata` = 0; `err_range` = 1.
- Cases with reset or `hold` active:
  - `hold` = 1 with both masters requesting: both `waitrequest` = 1 and no memory command.
  - Reset asserted in the cycle a read is issued: no `readdatavalid` afterwards; all outputs at reset values.
